// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD frame feeder: controller opcodes,
// default panel geometry, feeder state encoding and the window-setup sequence.
package lcd_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   localparam int DEF_H_RES = 240;
   localparam int DEF_V_RES = 320;

   localparam logic [3:0] WIN_LAST = 4'd10;

   typedef enum logic [1:0] {
      WAIT_TE = 2'd0,
      WINDOW  = 2'd1,
      PIX_HI  = 2'd2,
      PIX_LO  = 2'd3
   } state_e;

   // Bit 8 is RS: commands go out with RS low, their arguments with RS high.
   function automatic logic [8:0] window_word(input logic [3:0]  idx,
                                              input logic [15:0] col_last,
                                              input logic [15:0] row_last);
      logic [8:0] w;
      case (idx)
         4'd0:       w = {1'b0, CMD_CASET};
         4'd1, 4'd2: w = 9'h100;
         4'd3:       w = {1'b1, col_last[15:8]};
         4'd4:       w = {1'b1, col_last[7:0]};
         4'd5:       w = {1'b0, CMD_PASET};
         4'd6, 4'd7: w = 9'h100;
         4'd8:       w = {1'b1, row_last[15:8]};
         4'd9:       w = {1'b1, row_last[7:0]};
         4'd10:      w = {1'b0, CMD_RAMWR};
         default:    w = 9'h000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/lcd_frame_feeder_if.sv
// Pixel-in / LCD-word-out bundle of the frame feeder. The feeder itself uses
// the master view; the pixel source and the bus writer use the slave view.
interface lcd_frame_feeder_if;

   logic [15:0] pix_data;
   logic        pix_sof;
   logic        pix_valid;
   logic        pix_ready;
   logic        lcd_fmark;
   logic [8:0]  word;
   logic        word_valid;
   logic        word_ready;
   logic        frame_done;
   logic        sync_err;

   modport master (
      input  pix_data, pix_sof, pix_valid, lcd_fmark, word_ready,
      output pix_ready, word, word_valid, frame_done, sync_err
   );

   modport slave (
      output pix_data, pix_sof, pix_valid, lcd_fmark, word_ready,
      input  pix_ready, word, word_valid, frame_done, sync_err
   );

endinterface

// File: rtl/lcd_te_sync.sv
// Brings the asynchronous tearing-effect line into the i_clk domain and
// flags its rising edges.
module lcd_te_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic fmark,
   output logic te_rise
);

   logic sync0_r;
   logic sync1_r;
   logic prev_r;

   // Two synchronizer stages plus one delayed copy for edge detection.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync0_r <= 1'b0;
         sync1_r <= 1'b0;
         prev_r  <= 1'b0;
      end else begin
         sync0_r <= fmark;
         sync1_r <= sync0_r;
         prev_r  <= sync1_r;
      end
   end

   assign te_rise = sync1_r & ~prev_r;

endmodule

// File: rtl/lcd_frame_feeder.sv
// Waits for the panel's TE edge, programs the full-screen window and then
// streams RGB565 pixels as high/low data bytes towards the LCD bus writer.
module lcd_frame_feeder
   import lcd_pkg::*;
#(
   parameter int H_RES = DEF_H_RES,
   parameter int V_RES = DEF_V_RES
) (
   input  logic               i_clk,
   input  logic               i_reset,
   lcd_frame_feeder_if.master bus
);

   localparam logic [15:0] COL_LAST = 16'(H_RES - 1);
   localparam logic [15:0] ROW_LAST = 16'(V_RES - 1);
   localparam logic [16:0] PIX_LAST = 17'(H_RES * V_RES - 1);

   state_e      state_r;
   state_e      next_state_s;
   logic [3:0]  win_idx_r;
   logic [16:0] pix_cnt_r;
   logic        te_seen_r;
   logic [7:0]  lo_byte_r;
   logic [8:0]  word_r;
   logic        word_valid_r;
   logic        last_r;
   logic        frame_done_r;
   logic        sync_err_r;

   logic        te_rise_s;
   logic        slot_free_s;
   logic        cnt_zero_s;
   logic        bad_sof_s;
   logic        hi_take_s;
   logic        pix_ready_s;
   logic        load_s;
   logic [8:0]  load_word_s;
   logic        load_last_s;
   logic        latch_s;
   logic        win_inc_s;
   logic        cnt_clr_s;
   logic        cnt_inc_s;
   logic        sync_err_s;

   lcd_te_sync u_te_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .fmark   (bus.lcd_fmark),
      .te_rise (te_rise_s)
   );

   assign slot_free_s = ~word_valid_r | bus.word_ready;
   assign cnt_zero_s  = (pix_cnt_r == 17'd0);
   // A frame must open with SOF; any later SOF means the source lost sync.
   assign bad_sof_s   = bus.pix_valid & bus.pix_sof & ~cnt_zero_s;
   assign hi_take_s   = bus.pix_valid & slot_free_s & (bus.pix_sof == cnt_zero_s);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r <= WAIT_TE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         WAIT_TE: begin
            if (te_seen_r) next_state_s = WINDOW;
            else           next_state_s = WAIT_TE;
         end
         WINDOW: begin
            if (slot_free_s && (win_idx_r == WIN_LAST)) next_state_s = PIX_HI;
            else                                        next_state_s = WINDOW;
         end
         PIX_HI: begin
            if (bad_sof_s)      next_state_s = WAIT_TE;
            else if (hi_take_s) next_state_s = PIX_LO;
            else                next_state_s = PIX_HI;
         end
         PIX_LO: begin
            if (!slot_free_s)                next_state_s = PIX_LO;
            else if (pix_cnt_r == PIX_LAST)  next_state_s = WAIT_TE;
            else                             next_state_s = PIX_HI;
         end
         default: next_state_s = WAIT_TE;
      endcase
   end

   // Output and datapath-control decode.
   always_comb begin
      pix_ready_s = 1'b0;
      load_s      = 1'b0;
      load_word_s = 9'h000;
      load_last_s = 1'b0;
      latch_s     = 1'b0;
      win_inc_s   = 1'b0;
      cnt_clr_s   = 1'b0;
      cnt_inc_s   = 1'b0;
      sync_err_s  = 1'b0;
      case (state_r)
         WAIT_TE: begin
            pix_ready_s = 1'b0;
         end
         WINDOW: begin
            if (slot_free_s) begin
               load_s      = 1'b1;
               load_word_s = window_word(win_idx_r, COL_LAST, ROW_LAST);
               win_inc_s   = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         PIX_HI: begin
            // Pre-SOF pixels are accepted here but never turned into words.
            pix_ready_s = slot_free_s & ~bad_sof_s;
            if (bad_sof_s) begin
               sync_err_s = 1'b1;
               cnt_clr_s  = 1'b1;
            end else if (hi_take_s) begin
               load_s      = 1'b1;
               load_word_s = {1'b1, bus.pix_data[15:8]};
               latch_s     = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         PIX_LO: begin
            if (slot_free_s) begin
               load_s      = 1'b1;
               load_word_s = {1'b1, lo_byte_r};
               if (pix_cnt_r == PIX_LAST) begin
                  load_last_s = 1'b1;
                  cnt_clr_s   = 1'b1;
               end else begin
                  cnt_inc_s = 1'b1;
               end
            end else begin
               load_s = 1'b0;
            end
         end
         default: begin
            pix_ready_s = 1'b0;
         end
      endcase
   end

   // Window index, pixel counter and the held low byte.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         win_idx_r <= 4'd0;
         pix_cnt_r <= 17'd0;
         lo_byte_r <= 8'h00;
      end else begin
         if (state_r == WAIT_TE) win_idx_r <= 4'd0;
         else if (win_inc_s)     win_idx_r <= win_idx_r + 4'd1;
         else                    win_idx_r <= win_idx_r;

         if (cnt_clr_s)      pix_cnt_r <= 17'd0;
         else if (cnt_inc_s) pix_cnt_r <= pix_cnt_r + 17'd1;
         else                pix_cnt_r <= pix_cnt_r;

         if (latch_s) lo_byte_r <= bus.pix_data[7:0];
         else         lo_byte_r <= lo_byte_r;
      end
   end

   // Sticky TE flag; edges outside WAIT_TE belong to a frame already underway.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         te_seen_r <= 1'b0;
      end else if ((state_r == WAIT_TE) && (next_state_s != WAIT_TE)) begin
         te_seen_r <= 1'b0;
      end else if ((state_r == WAIT_TE) && te_rise_s) begin
         te_seen_r <= 1'b1;
      end else begin
         te_seen_r <= te_seen_r;
      end
   end

   // Output word slot and status pulses.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         word_r       <= 9'h000;
         word_valid_r <= 1'b0;
         last_r       <= 1'b0;
         frame_done_r <= 1'b0;
         sync_err_r   <= 1'b0;
      end else begin
         frame_done_r <= word_valid_r & bus.word_ready & last_r;
         sync_err_r   <= sync_err_s;
         if (load_s) begin
            word_r       <= load_word_s;
            word_valid_r <= 1'b1;
            last_r       <= load_last_s;
         end else if (bus.word_ready) begin
            word_r       <= word_r;
            word_valid_r <= 1'b0;
            last_r       <= 1'b0;
         end else begin
            word_r       <= word_r;
            word_valid_r <= word_valid_r;
            last_r       <= last_r;
         end
      end
   end

   assign bus.pix_ready  = pix_ready_s;
   assign bus.word       = word_r;
   assign bus.word_valid = word_valid_r;
   assign bus.frame_done = frame_done_r;
   assign bus.sync_err   = sync_err_r;

endmodule

// File: tb/tb_lcd_frame_feeder.sv
// Directed bench for lcd_frame_feeder: a default-geometry instance for the
// window sequence and a 4x2 instance for complete frames and error handling.
module tb_lcd_frame_feeder;
   import lcd_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   rand_en = 1'b0;

   lcd_frame_feeder_if bd ();
   lcd_frame_feeder_if bs ();

   lcd_frame_feeder dut_d (.i_clk(clk), .i_reset(rst), .bus(bd));
   lcd_frame_feeder #(.H_RES(4), .V_RES(2)) dut_s (.i_clk(clk), .i_reset(rst), .bus(bs));

   localparam logic [8:0] WIN_DEF [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02B,
                                            9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};
   localparam logic [8:0] WIN_SMALL [11] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103, 9'h02B,
                                              9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};
   localparam logic [15:0] PIXELS [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                          16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};
   localparam logic [8:0] BYTES [16] = '{9'h112, 9'h134, 9'h156, 9'h178, 9'h19A, 9'h1BC,
                                         9'h1DE, 9'h1F0, 9'h10F, 9'h11E, 9'h12D, 9'h13C,
                                         9'h14B, 9'h15A, 9'h169, 9'h178};

   logic [8:0] got_d [$];
   int         stamp_d [$];
   logic [8:0] got_s [$];
   int         stamp_s [$];
   int         fd_n = 0;
   int         fd_cyc = 0;
   int         se_n = 0;
   int         last_xfer_s = 0;
   logic       hold_v = 1'b0;
   logic [8:0] hold_w = 9'h000;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every downstream transfer and pulse; check the word holds while stalled.
   always @(negedge clk) begin
      if (!rst) begin
         if (bd.word_valid && bd.word_ready) begin
            got_d.push_back(bd.word);
            stamp_d.push_back(cyc);
         end
         if (bs.word_valid && bs.word_ready) begin
            got_s.push_back(bs.word);
            stamp_s.push_back(cyc);
            last_xfer_s = cyc;
         end
         if (bs.frame_done) begin
            fd_n++;
            fd_cyc = cyc;
         end
         if (bs.sync_err) se_n++;
         if (hold_v) begin
            checks++;
            if (!bs.word_valid || bs.word !== hold_w) begin
               errors++;
               $display("FAIL stall_hold: got valid=%0b word=%03h, expected valid=1 word=%03h",
                        bs.word_valid, bs.word, hold_w);
            end
         end
         hold_v = bs.word_valid && !bs.word_ready;
         hold_w = bs.word;
      end else begin
         hold_v = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      got_d.delete();
      stamp_d.delete();
      got_s.delete();
      stamp_s.delete();
      fd_n = 0;
      se_n = 0;
   endtask

   task automatic te_pulse_s();
      bs.lcd_fmark = 1'b1;
      tick(3);
      bs.lcd_fmark = 1'b0;
   endtask

   task automatic send_pix(input logic [15:0] d, input logic sof, output bit ok);
      bs.pix_data  = d;
      bs.pix_sof   = sof;
      bs.pix_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bs.pix_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      bs.pix_valid = 1'b0;
      bs.pix_sof   = 1'b0;
   endtask

   task automatic send_frame(input int n_pix);
      bit ok;
      for (int i = 0; i < n_pix; i++) begin
         send_pix(PIXELS[i], (i == 0), ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL pix_accept: pixel %0d got accepted=0, expected accepted=1", i);
         end
      end
   endtask

   task automatic wait_frame_done();
      for (int i = 0; i < 600 && fd_n == 0; i++) tick(1);
      tick(3);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      checks++; if (bs.word_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", bs.word_valid); end
      checks++; if (bs.word !== 9'h000) begin errors++; $display("FAIL rst_word: got %03h expected 000", bs.word); end
      checks++; if (bs.pix_ready !== 1'b0) begin errors++; $display("FAIL rst_pix_ready: got %0b expected 0", bs.pix_ready); end
      checks++; if (bs.frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %0b expected 0", bs.frame_done); end
      checks++; if (bs.sync_err !== 1'b0) begin errors++; $display("FAIL rst_sync_err: got %0b expected 0", bs.sync_err); end
      checks++; if (dut_s.state_r !== WAIT_TE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", dut_s.state_r, WAIT_TE); end
      checks++; if (bd.word_valid !== 1'b0) begin errors++; $display("FAIL rst_valid_def: got %0b expected 0", bd.word_valid); end
      rst = 1'b0;
      tick(5);
      checks++; if (bs.word_valid !== 1'b0) begin errors++; $display("FAIL idle_no_te: got valid=%0b expected 0", bs.word_valid); end
   endtask

   task automatic test_window_default();
      clear_logs();
      bd.lcd_fmark = 1'b1;
      tick(3);
      bd.lcd_fmark = 1'b0;
      tick(30);
      checks++;
      if (got_d.size() !== 11) begin errors++; $display("FAIL win_def_count: got %0d expected 11", got_d.size()); end
      for (int i = 0; i < 11 && i < got_d.size(); i++) begin
         checks++;
         if (got_d[i] !== WIN_DEF[i]) begin errors++; $display("FAIL win_def[%0d]: got %03h expected %03h", i, got_d[i], WIN_DEF[i]); end
      end
      if (got_d.size() >= 11) begin
         checks++;
         if (stamp_d[10] - stamp_d[0] !== 10) begin errors++; $display("FAIL win_def_rate: got span %0d expected 10", stamp_d[10] - stamp_d[0]); end
      end
      checks++; if (bd.pix_ready !== 1'b1) begin errors++; $display("FAIL win_def_stall_ready: got %0b expected 1", bd.pix_ready); end
      checks++; if (bd.word_valid !== 1'b0) begin errors++; $display("FAIL win_def_stall_valid: got %0b expected 0", bd.word_valid); end
   endtask

   task automatic test_frame();
      clear_logs();
      te_pulse_s();
      send_frame(8);
      wait_frame_done();
      checks++;
      if (got_s.size() !== 27) begin errors++; $display("FAIL frame_count: got %0d expected 27", got_s.size()); end
      for (int i = 0; i < 27 && i < got_s.size(); i++) begin
         checks++;
         if (got_s[i] !== ((i < 11) ? WIN_SMALL[i] : BYTES[i - 11])) begin
            errors++;
            $display("FAIL frame_word[%0d]: got %03h expected %03h", i, got_s[i], (i < 11) ? WIN_SMALL[i] : BYTES[i - 11]);
         end
      end
      if (got_s.size() >= 27) begin
         checks++;
         if (stamp_s[26] - stamp_s[11] !== 15) begin errors++; $display("FAIL frame_rate: got span %0d expected 15", stamp_s[26] - stamp_s[11]); end
      end
      checks++; if (fd_n !== 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", fd_n); end
      checks++; if (fd_cyc !== last_xfer_s + 1) begin errors++; $display("FAIL frame_done_time: got cycle %0d expected %0d", fd_cyc, last_xfer_s + 1); end
      checks++; if (dut_s.state_r !== WAIT_TE) begin errors++; $display("FAIL frame_end_state: got %0d expected %0d", dut_s.state_r, WAIT_TE); end
      checks++; if (se_n !== 0) begin errors++; $display("FAIL frame_sync_err: got %0d expected 0", se_n); end
   endtask

   task automatic test_ready_toggle();
      clear_logs();
      rand_en = 1'b1;
      fork
         begin
            while (rand_en) begin
               @(posedge clk);
               #1;
               bs.word_ready = 1'($urandom_range(0, 1));
            end
            bs.word_ready = 1'b1;
         end
      join_none
      te_pulse_s();
      send_frame(8);
      wait_frame_done();
      rand_en = 1'b0;
      tick(3);
      checks++;
      if (got_s.size() !== 27) begin errors++; $display("FAIL toggle_count: got %0d expected 27", got_s.size()); end
      for (int i = 0; i < 27 && i < got_s.size(); i++) begin
         checks++;
         if (got_s[i] !== ((i < 11) ? WIN_SMALL[i] : BYTES[i - 11])) begin
            errors++;
            $display("FAIL toggle_word[%0d]: got %03h expected %03h", i, got_s[i], (i < 11) ? WIN_SMALL[i] : BYTES[i - 11]);
         end
      end
      checks++; if (fd_n !== 1) begin errors++; $display("FAIL toggle_done_count: got %0d expected 1", fd_n); end
      checks++; if (fd_cyc !== last_xfer_s + 1) begin errors++; $display("FAIL toggle_done_time: got cycle %0d expected %0d", fd_cyc, last_xfer_s + 1); end
   endtask

   task automatic test_drop_pre_sof();
      bit ok;
      logic [15:0] junk [3] = '{16'hDEAD, 16'hBEEF, 16'hCAFE};
      clear_logs();
      te_pulse_s();
      for (int i = 0; i < 3; i++) begin
         send_pix(junk[i], 1'b0, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL drop_accept: junk %0d got accepted=0, expected accepted=1", i); end
      end
      send_frame(8);
      wait_frame_done();
      checks++;
      if (got_s.size() !== 27) begin errors++; $display("FAIL drop_count: got %0d expected 27", got_s.size()); end
      if (got_s.size() >= 13) begin
         checks++; if (got_s[11] !== 9'h112) begin errors++; $display("FAIL drop_first_hi: got %03h expected 112", got_s[11]); end
         checks++; if (got_s[12] !== 9'h134) begin errors++; $display("FAIL drop_first_lo: got %03h expected 134", got_s[12]); end
      end
      checks++; if (fd_n !== 1) begin errors++; $display("FAIL drop_done_count: got %0d expected 1", fd_n); end
   endtask

   task automatic test_sync_err();
      bit seen_ready = 1'b0;
      clear_logs();
      te_pulse_s();
      send_frame(3);
      bs.pix_data  = 16'h5555;
      bs.pix_sof   = 1'b1;
      bs.pix_valid = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bs.pix_ready) seen_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      bs.pix_valid = 1'b0;
      bs.pix_sof   = 1'b0;
      tick(3);
      checks++; if (seen_ready !== 1'b0) begin errors++; $display("FAIL sync_consumed: got ready=1 expected ready=0"); end
      checks++; if (se_n !== 1) begin errors++; $display("FAIL sync_err_count: got %0d expected 1", se_n); end
      checks++; if (dut_s.state_r !== WAIT_TE) begin errors++; $display("FAIL sync_state: got %0d expected %0d", dut_s.state_r, WAIT_TE); end
      checks++; if (got_s.size() !== 17) begin errors++; $display("FAIL sync_drain_count: got %0d expected 17", got_s.size()); end
      if (got_s.size() >= 17) begin
         checks++; if (got_s[16] !== 9'h1BC) begin errors++; $display("FAIL sync_drain_last: got %03h expected 1BC", got_s[16]); end
      end
      clear_logs();
      te_pulse_s();
      tick(20);
      checks++;
      if (got_s.size() !== 11) begin errors++; $display("FAIL resync_count: got %0d expected 11", got_s.size()); end
      for (int i = 0; i < 11 && i < got_s.size(); i++) begin
         checks++;
         if (got_s[i] !== WIN_SMALL[i]) begin errors++; $display("FAIL resync_word[%0d]: got %03h expected %03h", i, got_s[i], WIN_SMALL[i]); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      clear_logs();
      te_pulse_s();
      tick(20);
      bs.word_ready = 1'b0;
      send_pix(16'h1234, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL mid_accept: got accepted=0 expected accepted=1"); end
      checks++; if (dut_s.state_r !== PIX_LO) begin errors++; $display("FAIL mid_pre_state: got %0d expected %0d", dut_s.state_r, PIX_LO); end
      checks++; if (bs.word_valid !== 1'b1 || bs.word !== 9'h112) begin errors++; $display("FAIL mid_pre_word: got valid=%0b word=%03h expected valid=1 word=112", bs.word_valid, bs.word); end
      rst = 1'b1;
      tick(1);
      checks++; if (bs.word_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", bs.word_valid); end
      checks++; if (bs.pix_ready !== 1'b0) begin errors++; $display("FAIL mid_pix_ready: got %0b expected 0", bs.pix_ready); end
      checks++; if (dut_s.state_r !== WAIT_TE) begin errors++; $display("FAIL mid_state: got %0d expected %0d", dut_s.state_r, WAIT_TE); end
      rst = 1'b0;
      bs.word_ready = 1'b1;
      tick(2);
   endtask

   initial begin
      bd.pix_data = 16'h0000; bd.pix_sof = 1'b0; bd.pix_valid = 1'b0;
      bd.lcd_fmark = 1'b0; bd.word_ready = 1'b1;
      bs.pix_data = 16'h0000; bs.pix_sof = 1'b0; bs.pix_valid = 1'b0;
      bs.lcd_fmark = 1'b0; bs.word_ready = 1'b1;
      test_reset();
      test_window_default();
      test_frame();
      test_ready_toggle();
      test_drop_pre_sof();
      test_sync_err();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
